uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, valid/ready handshake, configurable frame format (data width, parity, stop bits) and baud divisor. It replaces the fixed 8N1, 8-clocks-per-bit, single-word transmitter in the serial output path. The upstream encoder can queue several words without waiting for each frame to finish.

## Interface
Parameters:
- DATA_BITS, default 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, default 8: clk cycles per serial bit; minimum 2.
- PARITY, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- STOP_BITS, default 1: number of stop bits; 1 or 2.
- FIFO_DEPTH, default 4: input queue depth; power of 2, minimum 2.

Ports (clock and reset first):
- clk  input  1  Clock.
- rst_n  input  1  Reset; asynchronous, active-low.
- tx_valid  input  1  Upstream word valid.
- tx_data  input  DATA_BITS  Word to transmit.
- tx_ready  output  1  Queue can accept a word; equals !full.
- tx  output  1  Serial line; idles high.
- tx_busy  output  1  High when the FSM is not IDLE or the queue is non-empty.
- frame_done  output  1  One-cycle pulse at the end of the last stop bit.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  Number of words queued, excluding the word being sent.

## Operation
- Push: a word is written on any edge where tx_valid && tx_ready.
  - tx_valid while tx_ready=0 is ignored; the word is not stored and no error is raised.
  - Upstream holds tx_data stable until accepted.
- FIFO: circular buffer with wrapping read and write pointers.
  - Simultaneous push and pop is legal when not full; fifo_count is then unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1; counters zeroed. If the queue is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles. After the last bit, go to PAR if PARITY!=0, otherwise STOP.
  - PAR: send the parity bit for CLKS_PER_BIT cycles.
    - Even: XOR of the data bits.
    - Odd: inverted XOR of the data bits.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - On the final cycle, pulse frame_done.
    - If the queue is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Counters:
  - Baud counter width is $clog2(CLKS_PER_BIT); it wraps at CLKS_PER_BIT-1.
  - Bit counter width is $clog2(DATA_BITS+1).
  - Parity is computed from the popped word when it is loaded, so later pushes cannot affect the frame in flight.
- tx is a registered output with no combinational path from any input.

## Timing
- Reset values: tx=1, tx_ready=1, tx_busy=0, frame_done=0, fifo_count=0, state=IDLE, FIFO empty.
- Reset mid-frame: tx returns high asynchronously, all queued words are discarded, and no frame_done pulse is generated.
- Latency: word accepted at edge N into an empty queue with an idle FSM:
  - fifo_count=1 after edge N.
  - Pop and tx=0 at edge N+1; fifo_count=0.
  - tx_ready never deasserts for a single word when FIFO_DEPTH>=2.
- Frame length: F = CLKS_PER_BIT*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles, from the tx falling edge to the end of the last stop bit.
- Back-to-back frames: the next start bit begins on the edge after the final stop cycle, so frames are exactly F apart.
- Full queue: with FIFO_DEPTH words queued, tx_ready=0. tx_ready rises on the edge after the next pop.
- tx_busy falls on the edge after the last frame_done when the queue is empty.

## Test plan
1. Defaults (8N1, CLKS_PER_BIT=8): push 0xA5 once.
   - tx low for 8 cycles, then data bits 1,0,1,0,0,1,0,1 (8 cycles each), then high for 8 cycles.
   - frame_done pulses 80 cycles after tx falls; tx_busy clears one cycle later.
2. PARITY=1, then PARITY=2: push 0xA5.
   - Parity bit is 0 for even and 1 for odd.
   - Frame is 88 cycles; STOP_BITS=2 extends it to 96 cycles.
3. DATA_BITS=7, CLKS_PER_BIT=3: push 0x7F.
   - 7 ones follow the start bit; frame is 27 cycles. The upper input bit is never sent.
4. FIFO_DEPTH=4: hold tx_valid high with 0x01..0x06 while the first frame is in flight.
   - tx_ready drops at fifo_count=4.
   - Exactly 5 words are accepted.
   - Frames are contiguous with no idle gap, and each later word is accepted only after a pop.
5. Assert rst_n low mid-data-bit of frame 2 with words queued.
   - tx=1 immediately, fifo_count=0.
   - After release: no output until a new push, which is then sent correctly.
6. Pushes with tx_ready=0 are not stored. Simultaneous push and pop in STOP leaves fifo_count unchanged.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small circular input queue.
// The frame format (data bits, parity, stop bits) and the baud divisor are set by parameters.
// Ports:
//   clk, rst_n  : clock; asynchronous active-low reset
//   tx_valid    : upstream word valid
//   tx_data     : upstream word
//   tx_ready    : queue can accept a word (!full)
//   tx          : serial line, idles high
//   tx_busy     : transmitter active or queue non-empty
//   frame_done  : one-cycle pulse at the end of the last stop bit
//   fifo_count  : words queued, excluding the one being sent
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 tx_valid,
  input  logic [DATA_BITS-1:0]                 tx_data,
  output logic                                 tx_ready,
  output logic                                 tx,
  output logic                                 tx_busy,
  output logic                                 frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BDW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  localparam logic [BDW-1:0] BAUD_LAST = BDW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // ---------------------------------------------------------------- queue
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_n;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count_q;

  // Occupancy update; push and pop together leave it unchanged.
  always_comb begin
    count_n = count_q;
    case ({push, pop})
      2'b10:   count_n = count_q + CW'(1);
      2'b01:   count_n = count_q - CW'(1);
      default: count_n = count_q;
    endcase
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q  <= count_n;
      tx_ready <= (count_n != DEPTH_C);
    end
  end

  // Storage needs no reset; occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // ---------------------------------------------------------------- framer
  state_t               state_q, state_n;
  logic [BDW-1:0]       baud_q, baud_n;
  logic [BCW-1:0]       bitc_q, bitc_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q, par_n;
  logic                 tx_n;
  logic                 frame_done_n;
  logic                 baud_end;
  logic                 load_par;

  assign baud_end = (baud_q == BAUD_LAST);
  // Parity is captured at load so the frame is independent of later pushes.
  assign load_par = (^head) ^ (PARITY == 2);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bitc_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      tx_busy    <= 1'b0;
    end else begin
      state_q    <= state_n;
      baud_q     <= baud_n;
      bitc_q     <= bitc_n;
      shift_q    <= shift_n;
      par_q      <= par_n;
      tx         <= tx_n;
      frame_done <= frame_done_n;
      tx_busy    <= (state_q != IDLE) || (count_q != '0);
    end
  end

  // Next state; tx_n is the line level for the state being entered.
  always_comb begin
    state_n      = state_q;
    baud_n       = baud_q;
    bitc_n       = bitc_q;
    shift_n      = shift_q;
    par_n        = par_q;
    tx_n         = tx;
    frame_done_n = 1'b0;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        bitc_n = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = load_par;
          state_n = START;
          tx_n    = 1'b0;
        end
      end

      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bitc_n  = '0;
          state_n = DATA;
          tx_n    = shift_q[0];
        end else begin
          baud_n = baud_q + BDW'(1);
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bitc_q == DATA_LAST) begin
            bitc_n = '0;
            if (PARITY != 0) begin
              state_n = PAR;
              tx_n    = par_q;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bitc_n  = bitc_q + BCW'(1);
            shift_n = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_n    = shift_q[1];
          end
        end else begin
          baud_n = baud_q + BDW'(1);
        end
      end

      PAR: begin
        if (baud_end) begin
          baud_n  = '0;
          bitc_n  = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud_q + BDW'(1);
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (bitc_q == STOP_LAST) begin
            bitc_n       = '0;
            frame_done_n = 1'b1;
            // Chain straight into the next start bit when a word is waiting.
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = load_par;
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bitc_n = bitc_q + BCW'(1);
          end
        end else begin
          baud_n = baud_q + BDW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random-traffic bench for uart_tx_fifo in three frame formats.
// The reference model schedules each accepted word's frame by arithmetic on accept times.
module tb_uart_tx_fifo;

  logic clk;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned DB  = (g == 2) ? 7 : 8;
    localparam int unsigned CPB = (g == 0) ? 8 : (g == 1) ? 5 : 3;
    localparam int unsigned PAR = (g == 0) ? 0 : (g == 1) ? 1 : 2;
    localparam int unsigned STB = (g == 2) ? 2 : 1;
    localparam int unsigned DEP = (g == 0) ? 4 : (g == 1) ? 2 : 8;
    localparam int unsigned CW  = $clog2(DEP + 1);
    localparam longint FLEN  = longint'(CPB * (1 + DB + ((PAR != 0) ? 1 : 0) + STB));
    localparam longint EXP_F = (g == 0) ? 80 : (g == 1) ? 55 : 33;

    logic          rst_n;
    logic          tx_valid;
    logic [DB-1:0] tx_data;
    logic          tx_ready;
    logic          tx;
    logic          tx_busy;
    logic          frame_done;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
      .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(PAR),
      .STOP_BITS(STB), .FIFO_DEPTH(DEP)
    ) dut (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy),
      .frame_done(frame_done), .fifo_count(fifo_count)
    );

    // Accept edge, frame start edge and word of every word still relevant.
    longint      acc_q[$];
    longint      st_q[$];
    int unsigned wd_q[$];

    initial begin
      longint      t, s, b, last_start, fall_t, fd_t;
      bit          have_last, pending, rst_done, fall_seen, fd_seen, busy_chk;
      int          exp_cnt, pct;
      logic        exp_tx, exp_fd, exp_busy, in_data, odd_ones;
      int unsigned w;

      t = 0; last_start = 0; fall_t = 0; fd_t = 0;
      have_last = 0; pending = 0; rst_done = 0;
      fall_seen = 0; fd_seen = 0; busy_chk = 0;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
      repeat (2) @(negedge clk);
      check($sformatf("c%0d reset tx", g), longint'(tx), 1);
      check($sformatf("c%0d reset tx_ready", g), longint'(tx_ready), 1);
      check($sformatf("c%0d reset tx_busy", g), longint'(tx_busy), 0);
      check($sformatf("c%0d reset frame_done", g), longint'(frame_done), 0);
      check($sformatf("c%0d reset fifo_count", g), longint'(fifo_count), 0);
      rst_n = 1'b1;

      for (int c = 0; c < 6000; c++) begin
        @(posedge clk);
        t++;
        @(negedge clk);

        while (st_q.size() > 0 && st_q[0] + FLEN < t) begin
          void'(acc_q.pop_front());
          void'(st_q.pop_front());
          void'(wd_q.pop_front());
        end

        // Expected outputs after edge t.
        exp_tx = 1'b1; exp_fd = 1'b0; exp_busy = 1'b0; exp_cnt = 0; in_data = 1'b0;
        for (int k = 0; k < st_q.size(); k++) begin
          s = st_q[k];
          if (acc_q[k] <= t && t < s) exp_cnt++;
          if (acc_q[k] < t && t <= s + FLEN) exp_busy = 1'b1;
          if (t == s + FLEN) exp_fd = 1'b1;
          if (s + CPB <= t && t < s + CPB * (1 + DB)) in_data = 1'b1;
          if (s <= t && t < s + FLEN) begin
            b = (t - s) / CPB;
            w = wd_q[k];
            odd_ones = ($countones(w) % 2) == 1;
            if (b == 0) exp_tx = 1'b0;
            else if (b <= DB) exp_tx = ((w >> (b - 1)) & 1) != 0;
            else if (PAR != 0 && b == DB + 1) exp_tx = (PAR == 1) ? odd_ones : !odd_ones;
            else exp_tx = 1'b1;
          end
        end

        check($sformatf("c%0d tx@%0d", g, t), longint'(tx), longint'(exp_tx));
        check($sformatf("c%0d frame_done@%0d", g, t), longint'(frame_done), longint'(exp_fd));
        check($sformatf("c%0d tx_busy@%0d", g, t), longint'(tx_busy), longint'(exp_busy));
        check($sformatf("c%0d fifo_count@%0d", g, t), longint'(fifo_count), longint'(exp_cnt));
        check($sformatf("c%0d tx_ready@%0d", g, t), longint'(tx_ready), (exp_cnt < DEP) ? 1 : 0);

        // First, isolated frame: fall-to-done distance and busy release.
        if (!fall_seen && tx === 1'b0) begin
          fall_seen = 1; fall_t = t;
        end
        if (fall_seen && !fd_seen && frame_done === 1'b1) begin
          fd_seen = 1; fd_t = t;
          check($sformatf("c%0d first frame length", g), fd_t - fall_t, EXP_F);
        end
        if (fd_seen && !busy_chk && t == fd_t + 1) begin
          busy_chk = 1;
          check($sformatf("c%0d busy after first done", g), longint'(tx_busy), 0);
        end

        // Asynchronous reset in the middle of a data bit with words queued.
        if (!rst_done && c >= 3000 && exp_cnt > 0 && in_data) begin
          #2 rst_n = 1'b0;
          #1;
          check($sformatf("c%0d async rst tx", g), longint'(tx), 1);
          check($sformatf("c%0d async rst fifo_count", g), longint'(fifo_count), 0);
          check($sformatf("c%0d async rst tx_ready", g), longint'(tx_ready), 1);
          check($sformatf("c%0d async rst tx_busy", g), longint'(tx_busy), 0);
          check($sformatf("c%0d async rst frame_done", g), longint'(frame_done), 0);
          acc_q.delete(); st_q.delete(); wd_q.delete();
          have_last = 0; pending = 0; rst_done = 1;
          tx_valid = 1'b0;
          @(negedge clk);
          t++;
          rst_n = 1'b1;
          continue;
        end

        // Stimulus for edge t+1; an unaccepted word is held unchanged.
        if (!pending) begin
          pct = (c < 2000) ? 30 : (c < 4000) ? 90 : 50;
          if (c == 0) begin
            tx_valid = 1'b1;
            tx_data  = DB'(32'hA5);
          end else if (c < 150) begin
            tx_valid = 1'b0;
          end else begin
            tx_valid = ($urandom_range(0, 99) < pct);
            tx_data  = DB'($urandom);
          end
        end
        if (tx_valid && exp_cnt < DEP) begin
          s = t + 2;
          if (have_last && last_start + FLEN > s) s = last_start + FLEN;
          acc_q.push_back(t + 1);
          st_q.push_back(s);
          wd_q.push_back(32'(tx_data));
          last_start = s;
          have_last  = 1;
          pending    = 0;
        end else begin
          pending = tx_valid;
        end
      end

      check($sformatf("c%0d first frame observed", g), longint'(busy_chk), 1);
      check($sformatf("c%0d reset exercised", g), longint'(rst_done), 1);
      tx_valid = 1'b0;
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && n_done < 3; i++) @(posedge clk);
    check("all configs finished", longint'(n_done), 3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
